// File: rtl/tdm_demux16_if.sv
// rtl/tdm_demux16_if.sv - serial TDM input, frame output and status bundle for tdm_demux16
// ovf exists only when TDM_DEMUX_OVF_EN is defined.
interface tdm_demux16_if;
  logic        din;
  logic        din_valid;
  logic        frame_start;
  logic [15:0] Y;
  logic        Y_valid;
  logic        Y_ready;
  logic [3:0]  S;
  logic        sync_err;
`ifdef TDM_DEMUX_OVF_EN
  logic        ovf;
`endif

  modport master (
    output din, din_valid, frame_start, Y_ready,
`ifdef TDM_DEMUX_OVF_EN
    input  ovf,
`endif
    input  Y, Y_valid, S, sync_err
  );

  modport slave (
    input  din, din_valid, frame_start, Y_ready,
`ifdef TDM_DEMUX_OVF_EN
    output ovf,
`endif
    output Y, Y_valid, S, sync_err
  );
endinterface

// File: rtl/tdm_demux16.sv
// rtl/tdm_demux16.sv - 16-channel serial TDM demultiplexer with a one-deep frame output register
// Optional sticky overflow flag enabled by defining TDM_DEMUX_OVF_EN.
module tdm_demux16 (
  input  logic         clk,
  input  logic         rst_n,
  tdm_demux16_if.slave bus
);

  logic [15:0] r_part;
  logic [3:0]  r_s;
  logic [15:0] r_y;
  logic        r_y_valid;
  logic        r_sync_err;
`ifdef TDM_DEMUX_OVF_EN
  logic        r_ovf;
`endif

  logic [15:0] w_frame;
  logic        w_complete;
  logic        w_take;

  // Partial frame with the current slot bit merged in; this is the completed frame when S==15.
  always_comb begin
    w_frame        = r_part;
    w_frame[r_s]   = bus.din;
  end

  assign w_complete = bus.din_valid && !bus.frame_start && (r_s == 4'd15);
  assign w_take     = !r_y_valid || bus.Y_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_part     <= 16'h0000;
      r_s        <= 4'd0;
      r_y        <= 16'h0000;
      r_y_valid  <= 1'b0;
      r_sync_err <= 1'b0;
`ifdef TDM_DEMUX_OVF_EN
      r_ovf      <= 1'b0;
`endif
    end else begin
      r_sync_err <= 1'b0;
      if (bus.din_valid) begin
        if (bus.frame_start) begin
          r_sync_err <= (r_s != 4'd0);
          r_part     <= {15'd0, bus.din};
          r_s        <= 4'd1;
        end else begin
          r_part     <= w_frame;
          r_s        <= r_s + 4'd1;
        end
      end

      // A completion either replaces an accepted/empty Y or is dropped.
      if (w_complete) begin
        if (w_take) begin
          r_y       <= w_frame;
          r_y_valid <= 1'b1;
        end
`ifdef TDM_DEMUX_OVF_EN
        else begin
          r_ovf     <= 1'b1;
        end
`endif
      end else if (r_y_valid && bus.Y_ready) begin
        r_y_valid <= 1'b0;
      end
    end
  end

  assign bus.Y        = r_y;
  assign bus.Y_valid  = r_y_valid;
  assign bus.S        = r_s;
  assign bus.sync_err = r_sync_err;
`ifdef TDM_DEMUX_OVF_EN
  assign bus.ovf      = r_ovf;
`endif

endmodule

// File: doc/tdm_demux16.md
TDM_DEMUX16 -- requirements
Module: tdm_demux16

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-003 SHALL have port: din  input  1  serial TDM data bit for the current channel slot.
REQ-004 SHALL have port: din_valid  input  1  din carries a valid slot bit this cycle.
REQ-005 SHALL have port: frame_start  input  1  qualified by din_valid; marks the current bit as channel 0.
REQ-006 SHALL have port: Y  output  16  assembled frame; Y[i] = channel i bit.
REQ-007 SHALL have port: Y_valid  output  1  Y holds an unconsumed frame.
REQ-008 SHALL have port: Y_ready  input  1  consumer accepts Y when Y_valid && Y_ready.
REQ-009 SHALL have port: S  output  4  channel index the next valid bit is written to.
REQ-010 SHALL have port: sync_err  output  1  one-cycle pulse when frame_start arrives with S != 0.
REQ-011 SHALL have port: ovf  output  1  sticky overflow flag (present only with TDM_DEMUX_OVF_EN).

Function
REQ-012 SHALL, on each cycle with din_valid=1 and frame_start=0, write din into partial-frame register bit S, then increment S modulo 16.
REQ-013 SHALL, on din_valid=1 and frame_start=1, discard the partial frame, write din to bit 0, and set S to 1.
REQ-014 SHALL assert sync_err for exactly one cycle when frame_start is accepted while S != 0; no pulse when S == 0.
REQ-015 SHALL ignore din and frame_start when din_valid=0; S and the partial frame hold.
REQ-016 SHALL complete a frame on the edge that writes channel 15; S wraps to 0 on that edge.
REQ-017 SHALL load Y with the completed frame and set Y_valid on the completion edge (latency: Y visible the cycle after the channel-15 bit is sampled).
REQ-018 SHALL clear Y_valid on a cycle with Y_valid && Y_ready and no simultaneous completion.
REQ-019 SHALL, on completion coinciding with Y_valid && Y_ready, load the new frame and keep Y_valid=1.
REQ-020 SHALL, on completion while Y_valid=1 and Y_ready=0, drop the new frame and leave Y unchanged.
REQ-021 SHALL keep Y stable while Y_valid=1 and not accepted.
REQ-022 SHALL accept back-to-back frames at one bit per cycle with no idle slot required between frames.

Reset
REQ-023 SHALL, on rst_n=0, immediately set S=0, partial frame=0, Y=16'h0000, Y_valid=0, sync_err=0, ovf=0.
REQ-024 SHALL discard any partial frame and pending Y when reset asserts mid-frame.
REQ-025 SHALL resume sampling on the first rising edge after rst_n deasserts.

Configuration
REQ-026 SHALL, with TDM_DEMUX_OVF_EN defined, provide ovf, set on every REQ-020 drop, cleared only by reset.
REQ-027 SHALL, without TDM_DEMUX_OVF_EN, omit the ovf port and its register; the REQ-020 drop behaviour is unchanged.

Verification
REQ-028 SHALL cover: reset, frame_start+din_valid, then 16 bits of 16'hAAAA LSB-first, Y_ready=1 -> Y=16'hAAAA, Y_valid=1 for one cycle, S back to 0.
REQ-029 SHALL cover: 16'hAAAA then 16'h5555 back-to-back, Y_ready=0 -> Y stays 16'hAAAA, second frame dropped, ovf=1 (macro on).
REQ-030 SHALL cover: frame_start after 7 bits -> sync_err pulse, S=1, then next 15 bits complete a frame with the new channel-0 bit in Y[0].
REQ-031 SHALL cover: din_valid toggling 1/0 every cycle over a 16'h1234 frame -> Y=16'h1234 after 31 cycles, S holds during gaps.
REQ-032 SHALL cover: rst_n low after 9 bits, then a full 16'hFFFF frame -> Y=16'hFFFF, no stale bits, Y_valid=0 during reset.
REQ-033 SHALL cover: Y_valid=1 with Y_ready raised on the completion edge of frame 16'h0F0F -> Y=16'h0F0F, Y_valid stays 1, ovf=0.
